// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory, loads IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        accept;
  logic [31:0] target;

  // Handshake: a fetch completes in any cycle where imem_req & imem_ready are both
  // high; imem_req/imem_addr depend only on registered state and stay stable until then.
  assign accept = imem_req & imem_ready;
  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      skid_instr_q  <= 32'h0;
      skid_pc_q     <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ: begin
        if (redirect)                state_d = imem_ready ? S_REQ : S_DRAIN;
        else if (imem_ready && stall) state_d = S_HOLD;
      end
      S_HOLD:  if (redirect || !stall) state_d = S_REQ;
      S_DRAIN: if (imem_ready) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
    imem_addr = pc_q;
    dbg_state = state_q;
  end

  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    case (state_q)
      S_BOOT, S_HOLD: if (redirect) pc_d = target;
      S_REQ: begin
        if (redirect) begin
          if (imem_ready) pc_d = target;
          else            pend_pc_d = target;
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
          end
        end
      end
      S_DRAIN: begin
        // A redirect arriving during the drain replaces the pending target.
        if (redirect) begin
          pend_pc_d = target;
          if (imem_ready) pc_d = target;
        end else if (imem_ready) begin
          pc_d = pend_pc_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if (redirect) begin
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      if (state_q == S_REQ && imem_ready) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = pc_q;
        if_id_instr_d = imem_rdata;
      end else if (state_q == S_HOLD) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = skid_pc_q;
        if_id_instr_d = skid_instr_q;
      end else begin
        if_id_valid_d = 1'b0;
      end
    end
  end

  assign if_id_valid    = if_id_valid_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_q + 32'd4;
  assign if_id_instr    = if_id_valid_q ? if_id_instr_q : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q + (accept ? 32'd1 : 32'd0);
    perf_bubble_d = perf_bubble_q +
                    ((state_q != S_BOOT && !if_id_valid_q) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic [1:0]  dbg_state;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr;
  logic [1:0]  w_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_f, perf_b, w_perf_f, w_perf_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_f), .perf_bubble_cnt(perf_b),
`endif
    .dbg_state(dbg_state)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rstn(rstn), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata), .if_id_valid(w_valid),
    .if_id_pc(w_pc), .if_id_pc_plus4(w_pc4), .if_id_instr(w_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(w_perf_f), .perf_bubble_cnt(w_perf_b),
`endif
    .dbg_state(w_dbg)
  );

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);
  always_comb w_rdata    = mem_word(w_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fetch stream view: one outstanding address, an optional parked instruction,
  // an optional "discard the in-flight fetch then jump to pend" obligation.
  logic        m_boot, m_drain, m_buf_v, m_v;
  logic [31:0] m_addr, m_pend, m_buf_pc, m_buf_instr, m_pc, m_instr;
  logic        n_boot, n_drain, n_buf_v, n_v, issuing, acc, loaded;
  logic [31:0] n_addr, n_pend, n_buf_pc, n_buf_instr, n_pc, n_instr, tgt;

  always_comb begin
    n_boot = 1'b0; n_drain = m_drain; n_buf_v = m_buf_v; n_v = m_v;
    n_addr = m_addr; n_pend = m_pend; n_buf_pc = m_buf_pc;
    n_buf_instr = m_buf_instr; n_pc = m_pc; n_instr = m_instr;
    tgt     = redirect_pc & 32'hFFFF_FFFC;
    issuing = !m_boot && !m_buf_v;
    acc     = issuing && imem_ready;
    loaded  = 1'b0;
    if (redirect) begin
      n_v = 1'b0;
      n_buf_v = 1'b0;
      if (m_drain) begin
        if (acc) begin n_addr = tgt; n_drain = 1'b0; end
        else n_pend = tgt;
      end else if (issuing && !acc) begin
        n_drain = 1'b1;
        n_pend  = tgt;
      end else begin
        n_addr = tgt;
      end
    end else begin
      if (m_drain) begin
        if (acc) begin n_addr = m_pend; n_drain = 1'b0; end
      end else if (acc) begin
        if (stall) begin
          n_buf_v = 1'b1; n_buf_pc = m_addr; n_buf_instr = mem_word(m_addr);
        end else begin
          n_v = 1'b1; n_pc = m_addr; n_instr = mem_word(m_addr); loaded = 1'b1;
        end
        n_addr = m_addr + 32'd4;
      end else if (m_buf_v && !stall) begin
        n_v = 1'b1; n_pc = m_buf_pc; n_instr = m_buf_instr; n_buf_v = 1'b0;
        loaded = 1'b1;
      end
      if (!stall && !loaded) n_v = 1'b0;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_boot <= 1'b1; m_drain <= 1'b0; m_buf_v <= 1'b0; m_v <= 1'b0;
      m_addr <= 32'h0; m_pend <= 32'h0; m_buf_pc <= 32'h0; m_buf_instr <= 32'h0;
      m_pc <= 32'h0; m_instr <= NOP;
    end else begin
      m_boot <= n_boot; m_drain <= n_drain; m_buf_v <= n_buf_v; m_v <= n_v;
      m_addr <= n_addr; m_pend <= n_pend; m_buf_pc <= n_buf_pc;
      m_buf_instr <= n_buf_instr; m_pc <= n_pc; m_instr <= n_instr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("m_req", 32'(imem_req), 32'(!m_boot && !m_buf_v));
    if (!m_boot && !m_buf_v) chk("m_addr", imem_addr, m_addr);
    chk("m_valid", 32'(if_id_valid), 32'(m_v));
    if (m_v) begin
      chk("m_pc", if_id_pc, m_pc);
      chk("m_pc4", if_id_pc_plus4, m_pc + 32'd4);
      chk("m_instr", if_id_instr, m_instr);
    end else begin
      chk("m_nop", if_id_instr, NOP);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h4);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_wrap_addr", w_addr, WRAP_PC);
    #2 rstn = 1'b1;

    tick();  // first request visible
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("seq_valid0", 32'(if_id_valid), 32'h1);
    chk("seq_pc0", if_id_pc, 32'h0);
    chk("seq_pc4_0", if_id_pc_plus4, 32'h4);
    chk("seq_addr4", imem_addr, 32'h4);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    tick();
    chk("seq_pc1", if_id_pc, 32'h4);
    chk("seq_addr8", imem_addr, 32'h8);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", w_pc4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_bubble", 32'(if_id_valid), 32'h0);
      if (i == 0) begin
        chk("wrap_pc2", w_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_perf3", w_perf_f, 32'd3);
`endif
      end
      if (i == 2) drive(1'b0, 1'b0, 32'h0, 1'b1);
    end
    tick();
    chk("wait_pc8", if_id_pc, 32'h8);
    chk("wait_addr12", imem_addr, 32'hC);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_pc", if_id_pc, 32'h8);
    tick();
    chk("hold_req2", 32'(imem_req), 32'h0);
    chk("hold_pc2", if_id_pc, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("skid_pc12", if_id_pc, 32'hC);
    chk("skid_instr", if_id_instr, mem_word(32'hC));
    chk("skid_addr16", imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_redir_addr", imem_addr, 32'h20);
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    tick();
    chk("drain_addr", imem_addr, 32'h20);
    chk("drain_req", 32'(imem_req), 32'h1);
    chk("drain_valid", 32'(if_id_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("drain_addr2", imem_addr, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    tick();
    chk("redir_pc", if_id_pc, 32'h100);
    chk("redir_instr", if_id_instr, mem_word(32'h100));
    drive(1'b1, 1'b1, 32'h203, 1'b1);
    tick();
    chk("rs_valid", 32'(if_id_valid), 32'h0);
    chk("rs_instr", if_id_instr, NOP);
    chk("rs_addr", imem_addr, 32'h200);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("rs_pc", if_id_pc, 32'h200);
    chk("rs_addr2", imem_addr, 32'h204);

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    #2 rstn = 1'b0;
    tick();
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    chk("mid_rst_valid", 32'(if_id_valid), 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    #2 rstn = 1'b1;
    tick();
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'h1);

    repeat (3000) begin
      tick();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) < 7);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
